// File: rtl/dmem_port_arbiter.sv
// Arbiter and sequencer for the shared single-port data memory (load unit vs store unit).
// Define DMEM_RR_EN for round-robin tie breaking; otherwise loads win ties.
module dmem_port_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        ld_req,
    input  logic [11:0] ld_addr,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    input  logic        st_req,
    input  logic [11:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_be,
    output logic        st_gnt,
    output logic        st_done,
    output logic        mem_rw_mode,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_RET,
        ST_WR,
        RMW_RD,
        RMW_MRG,
        RMW_WR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic [31:0] merged;
    logic [31:0] merge_word;
    logic        pick_ld;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{ld_addr[1:0], st_addr[1:0]};

`ifdef DMEM_RR_EN
    // last_ld remembers whether the most recent grant went to the load unit
    logic last_ld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_ld <= 1'b0;
        end else if (ld_gnt || st_gnt) begin
            last_ld <= ld_gnt;
        end
    end

    assign pick_ld = ld_req && (!st_req || !last_ld);
`else
    assign pick_ld = ld_req;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are gated by reset so every output reads 0 while reset is held
    always_comb begin
        state_nxt = state;
        ld_gnt    = 1'b0;
        st_gnt    = 1'b0;
        case (state)
            IDLE: begin
                if (i_rst_n) begin
                    if (pick_ld) begin
                        ld_gnt    = 1'b1;
                        state_nxt = LD_RD;
                    end else if (st_req) begin
                        st_gnt    = 1'b1;
                        state_nxt = ((st_be == 4'hF) || (st_be == 4'h0)) ? ST_WR : RMW_RD;
                    end
                end
            end
            LD_RD:   state_nxt = LD_RET;
            LD_RET:  state_nxt = IDLE;
            ST_WR:   state_nxt = IDLE;
            RMW_RD:  state_nxt = RMW_MRG;
            RMW_MRG: state_nxt = RMW_WR;
            RMW_WR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_addr  <= 10'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
        end else if (ld_gnt) begin
            cap_addr  <= ld_addr[11:2];
        end else if (st_gnt) begin
            cap_addr  <= st_addr[11:2];
            cap_wdata <= st_wdata;
            cap_be    <= st_be;
        end
    end

    always_comb begin
        merge_word = 32'd0;
        for (int i = 0; i < 4; i++) begin
            merge_word[8*i +: 8] = cap_be[i] ? cap_wdata[8*i +: 8] : mem_rdata[8*i +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            merged <= 32'd0;
        end else if (state == RMW_MRG) begin
            merged <= merge_word;
        end
    end

    // Memory side depends only on state and captured operands, never on live requests
    always_comb begin
        busy        = (state != IDLE);
        ld_rvalid   = (state == LD_RET);
        ld_rdata    = (state == LD_RET) ? mem_rdata : 32'd0;
        st_done     = (state == ST_WR) || (state == RMW_WR);
        mem_addr    = (state == IDLE) ? 10'd0 : cap_addr;
        mem_rw_mode = ((state == ST_WR) && (cap_be != 4'h0)) || (state == RMW_WR);
        mem_wdata   = 32'd0;
        if (state == ST_WR) begin
            mem_wdata = cap_wdata;
        end else if (state == RMW_WR) begin
            mem_wdata = merged;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed spec cases plus random loads/stores
// against a word-level memory model. Honours DMEM_RR_EN for the tie-breaking case.
module tb_dmem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        ld_req;
    logic [11:0] ld_addr;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        st_req;
    logic [11:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        st_gnt;
    logic        st_done;
    logic        mem_rw_mode;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] mem     [0:63];
    logic [31:0] exp_mem [0:63];
    logic        preload_en;
    logic [5:0]  preload_addr;
    logic [31:0] preload_data;

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_gnt      (ld_gnt),
        .ld_rvalid   (ld_rvalid),
        .ld_rdata    (ld_rdata),
        .st_req      (st_req),
        .st_addr     (st_addr),
        .st_wdata    (st_wdata),
        .st_be       (st_be),
        .st_gnt      (st_gnt),
        .st_done     (st_done),
        .mem_rw_mode (mem_rw_mode),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous-read data memory, one-cycle latency; preload port used only under reset
    always @(posedge i_clk) begin
        if (preload_en) begin
            mem[preload_addr] <= preload_data;
        end else if (mem_rw_mode) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[5:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mergeModel(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic checkIdleOutputs(input string pfx);
        checkOutput({pfx, "_ld_gnt"},    32'(ld_gnt),      32'd0);
        checkOutput({pfx, "_ld_rvalid"}, 32'(ld_rvalid),   32'd0);
        checkOutput({pfx, "_ld_rdata"},  ld_rdata,         32'd0);
        checkOutput({pfx, "_st_gnt"},    32'(st_gnt),      32'd0);
        checkOutput({pfx, "_st_done"},   32'(st_done),     32'd0);
        checkOutput({pfx, "_rw_mode"},   32'(mem_rw_mode), 32'd0);
        checkOutput({pfx, "_mem_addr"},  32'(mem_addr),    32'd0);
        checkOutput({pfx, "_mem_wdata"}, mem_wdata,        32'd0);
        checkOutput({pfx, "_busy"},      32'(busy),        32'd0);
    endtask

    task automatic waitGnt(input bit is_ld, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if ((is_ld && ld_gnt) || (!is_ld && st_gnt)) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic applyReset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checkIdleOutputs("reset");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic applyStimulus_load(input logic [11:0] addr);
        bit          ok;
        logic [31:0] exp;
        exp = exp_mem[addr[7:2]];
        @(negedge i_clk);
        ld_req  = 1'b1;
        ld_addr = addr;
        waitGnt(1'b1, ok);
        checkOutput("ld_gnt_seen", 32'(ok), 32'd1);
        if (!ok) begin
            ld_req = 1'b0;
            return;
        end
        checkOutput("ld_busy_at_gnt", 32'(busy), 32'd0);
        @(posedge i_clk);
        #1 ld_req = 1'b0;
        @(negedge i_clk);
        checkOutput("ld_mem_addr", 32'(mem_addr), 32'(addr[11:2]));
        checkOutput("ld_rw_mode", 32'(mem_rw_mode), 32'd0);
        checkOutput("ld_rvalid_early", 32'(ld_rvalid), 32'd0);
        @(negedge i_clk);
        checkOutput("ld_rvalid", 32'(ld_rvalid), 32'd1);
        checkOutput("ld_rdata", ld_rdata, exp);
        @(negedge i_clk);
        checkOutput("ld_idle_after", 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus_store(input logic [11:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] be);
        bit          ok;
        logic [31:0] exp_word;
        logic [5:0]  word;
        word     = addr[7:2];
        exp_word = mergeModel(exp_mem[word], wdata, be);
        @(negedge i_clk);
        st_req   = 1'b1;
        st_addr  = addr;
        st_wdata = wdata;
        st_be    = be;
        waitGnt(1'b0, ok);
        checkOutput("st_gnt_seen", 32'(ok), 32'd1);
        if (!ok) begin
            st_req = 1'b0;
            return;
        end
        @(posedge i_clk);
        #1 st_req = 1'b0;
        @(negedge i_clk);
        checkOutput("st_mem_addr", 32'(mem_addr), 32'(addr[11:2]));
        if (be == 4'hF || be == 4'h0) begin
            checkOutput("st_done_full", 32'(st_done), 32'd1);
            checkOutput("st_rw_full", 32'(mem_rw_mode), 32'(be != 4'h0));
            if (be == 4'hF) begin
                checkOutput("st_wdata_full", mem_wdata, wdata);
            end
        end else begin
            checkOutput("rmw_rd_done", 32'(st_done), 32'd0);
            checkOutput("rmw_rd_rw", 32'(mem_rw_mode), 32'd0);
            @(negedge i_clk);
            checkOutput("rmw_mrg_done", 32'(st_done), 32'd0);
            checkOutput("rmw_mrg_rw", 32'(mem_rw_mode), 32'd0);
            @(negedge i_clk);
            checkOutput("rmw_wr_done", 32'(st_done), 32'd1);
            checkOutput("rmw_wr_rw", 32'(mem_rw_mode), 32'd1);
            checkOutput("rmw_wr_addr", 32'(mem_addr), 32'(addr[11:2]));
            checkOutput("rmw_wr_wdata", mem_wdata, exp_word);
        end
        exp_mem[word] = exp_word;
        @(negedge i_clk);
        checkOutput("st_idle_after", 32'(busy), 32'd0);
        checkOutput("st_mem_word", mem[word], exp_mem[word]);
    endtask

    initial begin
        bit          ok;
        int          grants_ld;
        int          grants_st;
        int          both_cycles;
        bit          seq[$];
        logic [31:0] tie_w;
        logic [5:0]  rw;

        i_rst_n    = 1'b0;
        ld_req     = 1'b0;
        ld_addr    = 12'd0;
        st_req     = 1'b0;
        st_addr    = 12'd0;
        st_wdata   = 32'd0;
        st_be      = 4'd0;
        preload_en = 1'b0;
        preload_addr = 6'd0;
        preload_data = 32'd0;

        // Preload memory and model while the DUT is held in reset
        for (int i = 0; i < 64; i++) begin
            @(negedge i_clk);
            preload_en   = 1'b1;
            preload_addr = 6'(i);
            preload_data = (i == 4) ? 32'hDEADBEEF : $urandom;
            exp_mem[i]   = preload_data;
        end
        @(negedge i_clk);
        preload_en = 1'b0;
        applyReset();

        $display("[TB] directed load/store cases");
        applyStimulus_load(12'h010);
        applyStimulus_store(12'h020, 32'h12345678, 4'hF);
        checkOutput("full_store_word8", mem[8], 32'h12345678);
        applyStimulus_store(12'h020, 32'hAABBCCDD, 4'hF);
        applyStimulus_store(12'h020, 32'h00EE0000, 4'b0100);
        checkOutput("rmw_word8", mem[8], 32'hAAEECCDD);
        applyStimulus_load(12'h020);
        applyStimulus_store(12'h024, 32'h5A5A5A5A, 4'h0);
        checkOutput("be0_word9_unchanged", mem[9], exp_mem[9]);

        $display("[TB] reset during read-modify-write");
        @(negedge i_clk);
        st_req   = 1'b1;
        st_addr  = 12'h030;
        st_wdata = 32'hFFFFFFFF;
        st_be    = 4'b0011;
        waitGnt(1'b0, ok);
        checkOutput("abort_gnt_seen", 32'(ok), 32'd1);
        @(posedge i_clk);
        #1 st_req = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("abort_busy_in_mrg", 32'(busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        checkIdleOutputs("abort");
        repeat (2) begin
            @(negedge i_clk);
            checkOutput("abort_no_done", 32'(st_done), 32'd0);
        end
        i_rst_n = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            checkOutput("abort_no_done_after", 32'(st_done), 32'd0);
        end
        checkOutput("abort_word12", mem[12], exp_mem[12]);
        applyStimulus_load(12'h030);

        $display("[TB] both requesters held high");
        applyReset();
        tie_w     = $urandom;
        grants_ld = 0;
        grants_st = 0;
        both_cycles = 0;
        @(negedge i_clk);
        ld_req   = 1'b1;
        ld_addr  = 12'h040;
        st_req   = 1'b1;
        st_addr  = 12'h044;
        st_wdata = tie_w;
        st_be    = 4'hF;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ld_gnt && st_gnt) both_cycles++;
            if (ld_gnt) begin
                grants_ld++;
                seq.push_back(1'b0);
            end else if (st_gnt) begin
                grants_st++;
                seq.push_back(1'b1);
            end
            @(negedge i_clk);
        end
        ld_req = 1'b0;
        st_req = 1'b0;
        for (int c = 0; c < 10 && busy; c++) @(negedge i_clk);
        checkOutput("tie_drained", 32'(busy), 32'd0);
        checkOutput("tie_single_grant", 32'(both_cycles), 32'd0);
`ifdef DMEM_RR_EN
        checkOutput("tie_enough_grants", 32'(seq.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < seq.size(); k++) begin
            checkOutput($sformatf("tie_order_%0d", k), 32'(seq[k]), 32'(k % 2));
        end
        exp_mem[17] = tie_w;
`else
        checkOutput("tie_store_starved", 32'(grants_st), 32'd0);
        checkOutput("tie_loads_flow", 32'(grants_ld >= 10), 32'd1);
`endif
        checkOutput("tie_word17", mem[17], exp_mem[17]);

        $display("[TB] random traffic");
        for (int n = 0; n < 30; n++) begin
            rw = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) begin
                applyStimulus_load({4'b0, rw, 2'($urandom)});
            end else begin
                applyStimulus_store({4'b0, rw, 2'($urandom)}, $urandom, 4'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Sequencer and arbiter for the single-port data memory shared by the load unit and the store unit of the RV32 core. Grants one requester at a time, drives the memory address/write controls, returns load data, and performs read-modify-write for sub-word stores. Sits between the execute-stage load/store units and the 1 KiB-word data memory (synchronous read, 1-cycle latency).

## Interface
- No parameters; the memory is fixed at 1024 words × 32 bits.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- ld_req  in  1  load request; held with ld_addr until ld_gnt.
- ld_addr  in  12  load byte address; bits [1:0] ignored.
- ld_gnt  out  1  one-cycle pulse; the load is accepted and ld_addr is captured.
- ld_rvalid  out  1  one-cycle pulse; ld_rdata is valid.
- ld_rdata  out  32  raw memory word; the load unit does extraction and sign extension.
- st_req  in  1  store request; held with st_addr, st_wdata and st_be until st_gnt.
- st_addr  in  12  store byte address; bits [1:0] ignored.
- st_wdata  in  32  store data, already lane-aligned.
- st_be  in  4  byte enables; bit i selects byte lane [8i+7:8i].
- st_gnt  out  1  one-cycle pulse; the store is accepted and its operands are captured.
- st_done  out  1  one-cycle pulse; the store is complete in memory.
- mem_rw_mode  out  1  0 = read, 1 = write.
- mem_addr  out  10  word address, equal to captured addr[11:2].
- mem_wdata  out  32  write data; valid when mem_rw_mode = 1.
- mem_rdata  in  32  memory read data; valid one cycle after a read address is presented.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LD_RD, LD_RET, ST_WR, RMW_RD, RMW_MRG, RMW_WR.
- IDLE
  - Arbitrates only in IDLE; at most one grant per cycle.
  - A load grant goes to LD_RD.
  - A store grant with st_be = 4'hF or st_be = 4'h0 goes to ST_WR.
  - Any other store grant goes to RMW_RD.
- LD_RD: drive mem_addr = captured word address, mem_rw_mode = 0; go to LD_RET.
- LD_RET: ld_rvalid = 1, ld_rdata = mem_rdata; go to IDLE.
- ST_WR: mem_wdata = captured data, mem_rw_mode = 1 (stays 0 when st_be = 0, so no write occurs); st_done = 1; go to IDLE.
- RMW_RD: read the word (mem_rw_mode = 0); go to RMW_MRG.
- RMW_MRG: merge into a register, lane i = st_be[i] ? st_wdata lane i : mem_rdata lane i; go to RMW_WR.
- RMW_WR: mem_wdata = merged word, mem_rw_mode = 1, st_done = 1; go to IDLE.
- In IDLE, mem_addr = 0, mem_rw_mode = 0, mem_wdata = 0.
- All memory-facing outputs are driven from registered state only, never combinationally from requester inputs.
- Ordering: requests are serialized, so a load granted after st_done observes the stored data.
- Arbitration with both requests in IDLE: see Configuration. A single requester is always granted immediately.

## Timing
- Grant in cycle T (IDLE); captured operands are used from T+1.
- Load: memory read at T+1, ld_rvalid at T+2; next grant at T+3 at the earliest.
- Full-word store or st_be = 0: st_done at T+1; next grant at T+2.
- Partial store: read at T+1, merge at T+2, write and st_done at T+3; next grant at T+4.
- Reset values: every output is 0 (ld_gnt, ld_rvalid, ld_rdata, st_gnt, st_done, mem_rw_mode, mem_addr, mem_wdata, busy). State is IDLE and the priority pointer selects load.
- Reset asserted mid-operation
  - Aborts immediately; outputs go to 0 asynchronously.
  - A partial store aborted before RMW_WR leaves memory unmodified.
  - No ld_rvalid or st_done is issued for the aborted request.
- A requester dropping req before its grant is legal; nothing happens.
- A requester keeping req high after its grant is treated as a new request.

## Configuration
- DMEM_RR_EN defined: round-robin arbitration.
  - A 1-bit last-served register updates on each grant.
  - When both requests are pending, the requester not served last wins.
  - After reset, load wins the first tie.
- DMEM_RR_EN undefined: fixed priority, load always wins ties; no last-served register exists.

## Test plan
- Reset then ld_req, ld_addr = 12'h010, memory word 4 = 32'hDEADBEEF -> ld_gnt at T, mem_addr = 10'h004 at T+1, ld_rvalid with ld_rdata = 32'hDEADBEEF at T+2.
- st_req, st_addr = 12'h020, st_wdata = 32'h12345678, st_be = 4'hF -> st_gnt at T, write of 32'h12345678 to word 8 at T+1, st_done at T+1.
- Word 8 = 32'hAABBCCDD; store st_wdata = 32'h00EE0000, st_be = 4'b0100 -> write 32'hAAEECCDD at T+3, st_done at T+3; a following load returns 32'hAAEECCDD.
- ld_req and st_req held continuously high
  - With DMEM_RR_EN: grants alternate load, store, load, store.
  - Without DMEM_RR_EN: store is never granted while ld_req stays high.
- i_rst_n pulsed low in RMW_MRG -> all outputs 0, no memory write, no st_done; the target word is unchanged.
- st_be = 4'h0 -> st_gnt, then st_done at T+1 with mem_rw_mode held at 0 throughout.
